alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter AW, default 4, meaning program memory address width; depth = 2^AW instruction words.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 prog_we  input  1  program memory write strobe.
REQ-005 prog_addr  input  AW  program memory write address.
REQ-006 prog_data  input  18  instruction word: [17] halt, [16] load, [15] cin, [14:8] opcode (reg select [14:12], ALU op [11:8]), [7:0] data.
REQ-007 start  input  1  single-cycle request to run the program from address 0.
REQ-008 abort  input  1  terminates a running program.
REQ-009 cpu_acc  input  8  accumulator value from the CPU datapath (its data_out).
REQ-010 cpu_cout  input  1  carry output from the CPU datapath.
REQ-011 cpu_ce, cpu_load  output  1 each  command strobes to the CPU datapath.
REQ-012 cpu_opcode  output  7  opcode to the CPU datapath; cpu_data  output  8  load data; cpu_cin  output  1  carry-in.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse on normal program completion.
REQ-015 result  output  8 and result_cout  output  1  accumulator and carry captured at completion.
REQ-016 instr_count  output  8  number of instructions issued in the current or last run, saturating at 255.

Function
REQ-017 The block SHALL implement states IDLE, ISSUE, WAIT and DONE.
REQ-018 A prog_we write SHALL update memory in IDLE only; writes in any other state SHALL be ignored.
REQ-019 In IDLE, start SHALL clear pc and instr_count and enter ISSUE; start outside IDLE SHALL be ignored.
REQ-020 In ISSUE, the word mem[pc] SHALL be decoded combinationally in the same cycle.
REQ-021 Halt word: no strobe issued; next state DONE.
REQ-022 Load word: cpu_ce=1, cpu_load=1, cpu_opcode and cpu_data from the word, for one cycle; pc increments; state stays ISSUE; latency is 1 cycle per load.
REQ-023 Op word: cpu_ce=1, cpu_load=0, cpu_opcode and cpu_cin from the word, for one cycle; next state WAIT; WAIT lasts exactly 1 cycle, then pc increments and the state returns to ISSUE; latency is 2 cycles per op.
REQ-024 cpu_ce SHALL be 0 in IDLE, WAIT and DONE; cpu_data, cpu_opcode and cpu_cin SHALL be 0 whenever cpu_ce=0.
REQ-025 instr_count SHALL increment on each cycle with cpu_ce=1, saturating at 255.
REQ-026 Wrap-around: a non-halt word executed at pc=2^AW-1 SHALL act as an implicit halt (next state DONE, pc does not wrap).
REQ-027 In DONE, the block SHALL capture cpu_acc into result and cpu_cout into result_cout, pulse done for 1 cycle, and return to IDLE.
REQ-028 abort high in ISSUE or WAIT SHALL force cpu_ce=0 that cycle, with next state IDLE, no done pulse, and result unchanged; an operation already issued completes inside the CPU datapath.
REQ-029 abort and start together in IDLE: start SHALL win; abort is ignored in IDLE and DONE.

Reset
REQ-030 rst SHALL asynchronously force state IDLE, pc=0, and instr_count, result, result_cout, done, busy and all cpu_* outputs to 0; memory contents are unaffected.
REQ-031 rst asserted mid-run SHALL abandon the program immediately, with no done pulse.

Configuration
REQ-032 With macro ALU_SEQ_STEP_EN defined, input step (1 bit) SHALL exist, and ISSUE SHALL issue an instruction only in a cycle where step=1 (otherwise it holds with cpu_ce=0); halt words also require step.
REQ-033 With ALU_SEQ_STEP_EN undefined, the step port SHALL be absent and ISSUE SHALL proceed every cycle.

Verification
REQ-034 Write mem[0]=load R0 0x05, mem[1]=halt; start -> cycle 1 shows cpu_ce=1, cpu_load=1, cpu_opcode=7'h00, cpu_data=8'h05; done in cycle 3; instr_count=1.
REQ-035 Op word with opcode 7'h12, cin=1 -> one cycle with cpu_ce=1, cpu_load=0, cpu_cin=1, then one WAIT cycle with cpu_ce=0; next word issued on cycle 3.
REQ-036 Program of 16 load words with no halt (AW=4) -> 16 strobes, done after pc=15, instr_count=16.
REQ-037 abort asserted in the second ISSUE cycle -> no strobe that cycle, busy=0 on the next cycle, no done pulse, result unchanged.
REQ-038 prog_we during a run -> memory unchanged; rst mid-run -> all outputs 0 at once; rerun gives the original program behaviour.
REQ-039 With ALU_SEQ_STEP_EN defined and step held low for 5 cycles, then pulsed -> no strobes while step is low, exactly one instruction per step pulse.

Source files
------------

// File: rtl/alu_sequencer.sv
// Microprogram sequencer that steps a small instruction memory and drives a CPU datapath.
// Optional single-step gating is enabled with the ALU_SEQ_STEP_EN macro (adds the step input).
module alu_sequencer #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
`ifdef ALU_SEQ_STEP_EN
  input  logic          step,
`endif
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [17:0]   prog_data,
  input  logic          start,
  input  logic          abort,
  input  logic [7:0]    cpu_acc,
  input  logic          cpu_cout,
  output logic          cpu_ce,
  output logic          cpu_load,
  output logic [6:0]    cpu_opcode,
  output logic [7:0]    cpu_data,
  output logic          cpu_cin,
  output logic          busy,
  output logic          done,
  output logic [7:0]    result,
  output logic          result_cout,
  output logic [7:0]    instr_count,
  output logic [1:0]    state_dbg
);

  // Datapath command interface: cpu_ce is a single-cycle command strobe with no
  // back-pressure; cpu_load/cpu_opcode/cpu_data/cpu_cin qualify it and read as
  // zero whenever cpu_ce is low.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_PC = '1;

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] pc;
  logic          pc_inc;
  logic          run_start;
  logic [17:0]   mem [2**AW];
  logic [17:0]   word;
  logic          issue_en;
  logic          at_last;

  assign word    = mem[pc];
  assign at_last = (pc == LAST_PC);

`ifdef ALU_SEQ_STEP_EN
  assign issue_en = step;
`else
  assign issue_en = 1'b1;
`endif

  assign run_start = (state == S_IDLE) && start;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  // Program memory is only writable while the sequencer is idle; no reset so
  // the program survives rst.
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_inc     = 1'b0;
    cpu_ce     = 1'b0;
    cpu_load   = 1'b0;
    cpu_opcode = 7'h00;
    cpu_data   = 8'h00;
    cpu_cin    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (issue_en) begin
          if (word[17]) begin
            state_n = S_DONE;
          end else begin
            cpu_ce     = 1'b1;
            cpu_opcode = word[14:8];
            if (word[16]) begin
              cpu_load = 1'b1;
              cpu_data = word[7:0];
              // The last word acts as an implicit halt; pc never wraps.
              if (at_last) begin
                state_n = S_DONE;
              end else begin
                pc_inc = 1'b1;
              end
            end else begin
              cpu_cin = word[15];
              state_n = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (at_last) begin
          state_n = S_DONE;
        end else begin
          pc_inc  = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (run_start) begin
      pc <= '0;
    end else if (pc_inc) begin
      pc <= pc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= 8'h00;
    end else if (run_start) begin
      instr_count <= 8'h00;
    end else if (cpu_ce && (instr_count != 8'hFF)) begin
      instr_count <= instr_count + 8'h01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result      <= 8'h00;
      result_cout <= 1'b0;
    end else if (state == S_DONE) begin
      result      <= cpu_acc;
      result_cout <= cpu_cout;
    end
  end

endmodule
